// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the packed-BCD to binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR_TH   = 4'd8;
  localparam logic [3:0] BCD_CORR      = 4'd3;

  function automatic logic bcd_valid(input logic [3:0] digit);
    return digit <= BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit correction: a post-shift digit >= 8 loses 3.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] y
);

  assign y = (d >= BCD_CORR_TH) ? d - BCD_CORR : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per cycle).
// BCD digits ride in the top of the shift register; binary bits fall out into the low BIN_W bits.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int SW = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  if (DIGITS < 1 || DIGITS > 4) begin : g_chk_digits
    $error("bcd_to_bin_seq: DIGITS must be 1..4");
  end
  if (BIN_W != $clog2(10**DIGITS)) begin : g_chk_width
    $error("bcd_to_bin_seq: BIN_W must equal clog2(10**DIGITS)");
  end

  bcd_state_t      state;
  logic [SW-1:0]   shreg;
  logic [SW-1:0]   shifted;
  logic [SW-1:0]   shreg_nxt;
  logic [CW-1:0]   count;
  logic            any_bad;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (!bcd_valid(bcd[4*i +: 4])) any_bad = 1'b1;
  end

  // Correction acts on the already-shifted value within the same cycle.
  assign shifted = shreg >> 1;
  assign shreg_nxt[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .d (shifted[BIN_W + 4*g +: 4]),
      .y (shreg_nxt[BIN_W + 4*g +: 4])
    );
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      done  <= 1'b0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= {bcd, {BIN_W{1'b0}}};
            count <= CW'(BIN_W);
            if (any_bad) begin
              bin   <= '0;
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          shreg <= shreg_nxt;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bin   <= shreg_nxt[BIN_W-1:0];
            err   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The digit field must be drained completely by the final shift.
  a_field_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (state == SHIFT && count == CW'(1)) |-> (shreg_nxt[SW-1:BIN_W] == '0));

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench: stimulus pushes expected {bin, err}; monitors pop on each done pulse.
module tb_bcd_to_bin_seq;

  typedef struct packed {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start4;
  logic [7:0]  bcd;
  logic [15:0] bcd4;
  logic        busy, done, err, busy4, done4, err4;
  logic [6:0]  bin;
  logic [13:0] bin4;

  exp_t q2[$];
  exp_t q4[$];
  int checks   = 0;
  int failures = 0;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
    .busy(busy), .done(done), .bin(bin), .err(err)
  );

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bcd(bcd4),
    .busy(busy4), .done(done4), .bin(bin4), .err(err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done2 actual bin=%0d expected no done", bin);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("bin2", 32'(bin), 32'(e.bin));
        chk("err2", 32'(err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done4 actual bin=%0d expected no done", bin4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("bin4", 32'(bin4), 32'(e.bin));
        chk("err4", 32'(err4), 32'(e.err));
      end
    end
  end

  // Called in an IDLE cycle, #1 after an edge; returns #1 after an edge in IDLE.
  task automatic run2(input logic [7:0] code, input logic [6:0] eb, input logic ee);
    int lat;
    q2.push_back({14'(eb), ee});
    start = 1'b1; bcd = code;
    @(posedge clk); #1;
    start = 1'b0; bcd = 8'hFF;
    chk("busy_after_start2", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency2", lat, ee ? 0 : 7);
    @(posedge clk); #1;
    chk("idle_after_done2", 32'(busy), 32'd0);
  endtask

  task automatic run4(input logic [15:0] code, input logic [13:0] eb, input logic ee);
    int lat;
    q4.push_back({eb, ee});
    start4 = 1'b1; bcd4 = code;
    @(posedge clk); #1;
    start4 = 1'b0; bcd4 = 16'hFFFF;
    lat = 0;
    while (!done4 && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("latency4", lat, ee ? 0 : 14);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; bcd = '0; bcd4 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bin",  32'(bin), 0);
    chk("rst_err",  32'(err), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1-3: directed values, back-to-back, malformed digit then recovery
    run2(8'h99, 7'd99, 1'b0);
    run2(8'h00, 7'd0,  1'b0);
    run2(8'h15, 7'd15, 1'b0);
    run2(8'h09, 7'd9,  1'b0);
    run2(8'h3A, 7'd0,  1'b1);
    run2(8'h42, 7'd42, 1'b0);

    // 4: a second start while busy must be dropped
    q2.push_back({14'd57, 1'b0});
    start = 1'b1; bcd = 8'h57;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; start = 1'b1; bcd = 8'h11;
    @(posedge clk); #1; start = 1'b0; bcd = 8'h00;
    lat = 3;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency_ignored_start", lat, 7);
    repeat (12) @(posedge clk); #1;

    // 5: reset mid-conversion clears outputs at once, no done
    start = 1'b1; bcd = 8'h88;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_bin",  32'(bin), 0);
    chk("midrst_err",  32'(err), 0);
    chk("midrst_done", 32'(done), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    run2(8'h88, 7'd88, 1'b0);

    // 6: every 8-bit code; then 4-digit boundaries
    for (int c = 0; c < 256; c++) begin
      if ((c / 16) > 9 || (c % 16) > 9) run2(8'(c), 7'd0, 1'b1);
      else                              run2(8'(c), 7'((c / 16) * 10 + (c % 16)), 1'b0);
    end
    run4(16'h0000, 14'd0,    1'b0);
    run4(16'h9999, 14'd9999, 1'b0);
    run4(16'h1234, 14'd1234, 1'b0);
    run4(16'h0A00, 14'd0,    1'b1);

    repeat (5) @(posedge clk); #1;
    chk("q2_drained", q2.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
